mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 60 ++++++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory
// arbiter. It holds the FSM state enum, the grant-select enum and the
// doubleword alignment mask applied to every memory address.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      I_WAIT,
      D_WAIT
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_I,
      GNT_D
   } gnt_sel_e;

   // Clears byte-offset bits [2:0] so the result is a 64-bit word address.
   localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

   // Width of the starvation counter. It is wide enough for MAX_DWIN up to 15.
   localparam int unsigned DWIN_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant decision for the memory arbiter.
//   clk, rst  : clock, asynchronous active-low reset
//   idle      : arbiter FSM is in IDLE, so a grant may be issued
//   i_req/i_done, d_req/d_done : requests and their registered done pulses
//   gnt       : combinational grant select (GNT_NONE / GNT_I / GNT_D)
// Data has priority over fetch. A registered counter of consecutive data
// grants forces a fetch grant once it reaches MAX_DWIN.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_DWIN = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     idle,
   input  logic     i_req,
   input  logic     i_done,
   input  logic     d_req,
   input  logic     d_done,
   output gnt_sel_e gnt
);

   localparam logic [DWIN_W-1:0] DWIN_MAX = DWIN_W'(MAX_DWIN);

   logic [DWIN_W-1:0] dwin_q, dwin_d;
   logic              i_elig, d_elig, starve;

   always_comb begin
      // A request is not eligible in its own done cycle. This stops a
      // requester that still holds req high from being issued a second time.
      i_elig = i_req & ~i_done;
      d_elig = d_req & ~d_done;
      starve = i_elig & (dwin_q == DWIN_MAX);

      gnt = GNT_NONE;
      if (idle) begin
         if (d_elig && !starve) begin
            gnt = GNT_D;
         end else if (i_elig) begin
            gnt = GNT_I;
         end
      end

      dwin_d = dwin_q;
      if (!i_req || gnt == GNT_I) begin
         dwin_d = '0;
      end else if (gnt == GNT_D && dwin_q != DWIN_MAX) begin
         dwin_d = dwin_q + DWIN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwin_q <= '0;
      end else begin
         dwin_q <= dwin_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported 64-bit memory between the fetch
// port and the data (ld/sd) port.
//   clk, rst                         : clock, asynchronous active-low reset
//   i_req/i_addr/i_flush             : fetch request, byte address, branch flush
//   i_done/i_rdata                   : fetch completion pulse, 32-bit instruction
//   d_req/d_we/d_addr/d_wdata        : data request (load/store)
//   d_done/d_rdata                   : data completion pulse, load data
//   m_req/m_we/m_addr/m_wdata        : registered memory request fields
//   m_ack/m_rdata                    : memory completion, read data
//   stall_if/stall_mem               : combinational pipeline stalls
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned MAX_DWIN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic              i_done,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam logic [ADDR_W-1:0] A_MASK = ~ADDR_W'(~ALIGN_MASK);

   arb_state_e        state_q, state_d;
   logic              m_req_q, m_req_d;
   logic              m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic              i_done_q, i_done_d;
   logic              d_done_q, d_done_d;
   logic [31:0]       i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              flush_pend_q, flush_pend_d;
   gnt_sel_e          gnt;

   mem_arb_pick #(
      .MAX_DWIN(MAX_DWIN)
   ) u_pick (
      .clk   (clk),
      .rst   (rst),
      .idle  (state_q == IDLE),
      .i_req (i_req),
      .i_done(i_done_q),
      .d_req (d_req),
      .d_done(d_done_q),
      .gnt   (gnt)
   );

   always_comb begin
      state_d      = state_q;
      m_req_d      = m_req_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      i_done_d     = 1'b0;
      d_done_d     = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      flush_pend_d = flush_pend_q;

      case (state_q)
         IDLE: begin
            case (gnt)
               GNT_D: begin
                  state_d   = D_WAIT;
                  m_req_d   = 1'b1;
                  m_we_d    = d_we;
                  m_addr_d  = d_addr & A_MASK;
                  m_wdata_d = d_wdata;
               end
               GNT_I: begin
                  state_d  = I_WAIT;
                  m_req_d  = 1'b1;
                  m_we_d   = 1'b0;
                  m_addr_d = i_addr & A_MASK;
               end
               default: ;
            endcase
         end
         I_WAIT: begin
            if (m_ack) begin
               state_d      = IDLE;
               m_req_d      = 1'b0;
               i_rdata_d    = i_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
               // A flush seen during the wait or in the ack cycle itself
               // lets the memory transaction complete but discards its result.
               i_done_d     = ~(flush_pend_q | i_flush);
               flush_pend_d = 1'b0;
            end else begin
               flush_pend_d = flush_pend_q | i_flush;
            end
         end
         D_WAIT: begin
            if (m_ack) begin
               state_d  = IDLE;
               m_req_d  = 1'b0;
               d_done_d = 1'b1;
               if (!m_we_q) begin
                  d_rdata_d = m_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         m_req_q      <= m_req_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         i_done_q     <= i_done_d;
         d_done_q     <= d_done_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign m_req     = m_req_q;
   assign m_we      = m_we_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign i_done    = i_done_q;
   assign d_done    = d_done_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall_if  = i_req & ~i_done_q;
   assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized fetch/data traffic against a transaction-level
// reference of the arbiter plus a sparse memory, with an asynchronous reset
// applied while a data transaction is outstanding.
module tb_mem_arbiter;

   localparam int unsigned AW   = 64;
   localparam int unsigned DW   = 64;
   localparam int unsigned MAXW = 4;
   localparam int unsigned NCYC = 6000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0, i_flush = 1'b0, i_done;
   logic [AW-1:0] i_addr = '0;
   logic [31:0]   i_rdata;
   logic          d_req = 1'b0, d_we = 1'b0, d_done;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0, d_rdata;
   logic          m_req, m_we, m_ack = 1'b0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata = '0;
   logic          stall_if, stall_mem;

   mem_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .MAX_DWIN(MAXW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_flush  (i_flush),
      .i_done   (i_done),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_done   (d_done),
      .d_rdata  (d_rdata),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_ack    (m_ack),
      .m_rdata  (m_rdata),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Reference: who owns the memory (0 none, 1 fetch, 2 data), the fields
   // sent, the expected responses and the consecutive-data-grant tally.
   logic [63:0] mem [logic [63:0]];
   int          owner;
   logic [63:0] e_addr, e_wdata, e_d_rdata;
   logic        e_we, e_i_done, e_d_done;
   logic [31:0] e_i_rdata;
   int          dwin;
   bit          fpend;
   int          n_fetch, n_data, max_run, run;

   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
   endfunction

   task automatic model_reset();
      owner = 0; e_addr = '0; e_wdata = '0; e_d_rdata = '0; e_we = 1'b0;
      e_i_done = 1'b0; e_d_done = 1'b0; e_i_rdata = '0; dwin = 0; fpend = 1'b0;
   endtask

   // One clock edge of the reference, from the inputs the DUT samples.
   task automatic model_step();
      bit ie, de, gi, gd, nid, ndd;
      ie = i_req && !e_i_done;
      de = d_req && !e_d_done;
      gi = 1'b0; gd = 1'b0; nid = 1'b0; ndd = 1'b0;
      if (owner == 0) begin
         if (de && !(ie && dwin == int'(MAXW))) gd = 1'b1;
         else if (ie) gi = 1'b1;
         if (gd) begin
            owner = 2; e_addr = d_addr & ~64'h7; e_we = d_we; e_wdata = d_wdata;
            n_data++; if (i_req) run++;
         end else if (gi) begin
            owner = 1; e_addr = i_addr & ~64'h7; e_we = 1'b0;
            n_fetch++; run = 0;
         end
      end else if (owner == 1) begin
         if (m_ack) begin
            owner = 0;
            e_i_rdata = i_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
            nid = !fpend && !i_flush;
            fpend = 1'b0;
         end else if (i_flush) begin
            fpend = 1'b1;
         end
      end else begin
         if (m_ack) begin
            owner = 0; ndd = 1'b1;
            if (e_we) mem[e_addr] = e_wdata;
            else e_d_rdata = m_rdata;
         end
      end
      if (!i_req || gi) begin dwin = 0; run = 0; end
      else if (gd && dwin < int'(MAXW)) dwin++;
      if (run > max_run) max_run = run;
      e_i_done = nid;
      e_d_done = ndd;
   endtask

   task automatic check_outputs();
      chk("m_req", m_req, owner != 0);
      chk("m_addr", m_addr, e_addr);
      chk("m_we", m_we, e_we);
      if (owner != 0 && e_we) chk("m_wdata", m_wdata, e_wdata);
      chk("i_done", i_done, e_i_done);
      chk("d_done", d_done, e_d_done);
      chk("i_rdata", i_rdata, e_i_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
   endtask

   task automatic drive_inputs();
      // fetch requester
      i_flush = 1'b0;
      if (e_i_done) begin
         if ($urandom_range(0, 1) == 0) i_req = 1'b0;
         else i_addr = 64'($urandom_range(0, 511));
      end else if (!i_req) begin
         if ($urandom_range(0, 2) == 0) begin
            i_req = 1'b1; i_addr = 64'($urandom_range(0, 511));
         end
      end
      if (i_req && !e_i_done && $urandom_range(0, 9) == 0) begin
         i_flush = 1'b1; i_addr = 64'($urandom_range(0, 511));
      end
      // data requester: busy most of the time so fetch can be starved
      if (e_d_done || !d_req) begin
         if (e_d_done && $urandom_range(0, 3) == 0) d_req = 1'b0;
         else if (e_d_done || $urandom_range(0, 1) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 64'($urandom_range(0, 511));
            d_wdata = {$urandom, $urandom};
         end
      end
      // memory: random ack latency, noise on ack/rdata when idle
      if (owner != 0) begin
         m_ack   = ($urandom_range(0, 2) == 0);
         m_rdata = e_we ? {$urandom, $urandom} : mem_rd(e_addr);
      end else begin
         m_ack   = ($urandom_range(0, 3) == 0);
         m_rdata = {$urandom, $urandom};
      end
   endtask

   initial begin
      bit did_rst;
      did_rst = 1'b0;
      n_fetch = 0; n_data = 0; max_run = 0; run = 0;
      model_reset();
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs();
      chk("reset_m_wdata", m_wdata, 64'h0);
      chk("reset_stall_if", stall_if, 1'b0);
      rst = 1'b1;

      for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check_outputs();
         if (!did_rst && cyc > NCYC / 2 && owner == 2) begin
            // Reset mid data transaction: m_req drops at once and a late
            // ack must not complete anything.
            did_rst = 1'b1;
            rst = 1'b0;
            #1;
            chk("rst_async_m_req", m_req, 1'b0);
            chk("rst_async_d_done", d_done, 1'b0);
            m_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_late_ack_d_done", d_done, 1'b0);
            chk("rst_late_ack_m_req", m_req, 1'b0);
            model_reset();
            rst = 1'b1;
            m_ack = 1'b1;
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
         end
         drive_inputs();
         #1;
         chk("stall_if", stall_if, i_req && !e_i_done);
         chk("stall_mem", stall_mem, d_req && !e_d_done);
      end

      chk("saw_reset_case", did_rst, 1'b1);
      chk("max_data_run_bound", max_run <= int'(MAXW), 1'b1);
      chk("fetch_grants_seen", n_fetch > 20, 1'b1);
      chk("data_grants_seen", n_data > 20, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
